// File: rtl/knn_grid_scan.sv
// knn_grid_scan: splits a corner-defined bounding box into a GRID_W x GRID_H grid and streams
// cell centres (mode 0) or pixels with their owning cell (mode 1). Optional abort input: KNN_ABORT_EN.
module knn_grid_scan #(
    parameter int COORD_W     = 10,
    parameter int GRID_W_LOG2 = 2,
    parameter int GRID_H_LOG2 = 2,
    parameter int CNT_W       = 4
) (
    input  logic               clk_en,
    input  logic               reset,
    input  logic               dic_end,
    input  logic               knn_en,
    input  logic               mode_i,
    input  logic [COORD_W-1:0] postion_lu_x,
    input  logic [COORD_W-1:0] postion_lu_y,
    input  logic [COORD_W-1:0] postion_rd_x,
    input  logic [COORD_W-1:0] postion_rd_y,
    input  logic               out_ready,
`ifdef KNN_ABORT_EN
    input  logic               knn_abort_i,
`endif
    output logic               out_valid,
    output logic [COORD_W-1:0] i_o,
    output logic [COORD_W-1:0] j_o,
    output logic [CNT_W-1:0]   cnt_w_o,
    output logic [CNT_W-1:0]   cnt_h_o,
    output logic [COORD_W-1:0] wid_center_o,
    output logic [COORD_W-1:0] hei_center_o,
    output logic               busy_o,
    output logic               err_o,
    output logic               knn_fin_o
);
    localparam int BW = COORD_W + 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'((1 << GRID_W_LOG2) - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'((1 << GRID_H_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;
    state_t state;

    logic               knn_en_q;
    logic               mode_q;
    logic               primed;
    logic [COORD_W-1:0] lu_x_q, lu_y_q, rd_x_q, rd_y_q;
    logic [COORD_W-1:0] x_min, y_min, x_max, y_max;
    logic [BW-1:0]      cell_w, cell_h;
    logic [BW-1:0]      sub_x, sub_y;

    logic [COORD_W-1:0] g_x_min, g_x_max, g_y_min, g_y_max;
    logic [BW-1:0]      g_box_w, g_box_h;

    always_comb begin
        g_x_min = (lu_x_q < rd_x_q) ? lu_x_q : rd_x_q;
        g_x_max = (lu_x_q < rd_x_q) ? rd_x_q : lu_x_q;
        g_y_min = (lu_y_q < rd_y_q) ? lu_y_q : rd_y_q;
        g_y_max = (lu_y_q < rd_y_q) ? rd_y_q : lu_y_q;
        g_box_w = BW'(g_x_max) - BW'(g_x_min) + BW'(1);
        g_box_h = BW'(g_y_max) - BW'(g_y_min) + BW'(1);
    end

    logic [COORD_W-1:0] base_cx, base_cy, step_cx, step_cy;
    logic [COORD_W-1:0] n_i, n_j, n_cx, n_cy;
    logic [CNT_W-1:0]   n_cw, n_ch;
    logic [BW-1:0]      n_sx, n_sy;
    logic               col_last, row_last, is_last;

    // Successor of the beat currently on the outputs; centres advance by adding cell sizes.
    always_comb begin
        base_cx  = COORD_W'(BW'(x_min) + (cell_w >> 1));
        base_cy  = COORD_W'(BW'(y_min) + (cell_h >> 1));
        step_cx  = COORD_W'(BW'(wid_center_o) + cell_w);
        step_cy  = COORD_W'(BW'(hei_center_o) + cell_h);
        col_last = (cnt_w_o == LAST_COL);
        row_last = (cnt_h_o == LAST_ROW);
        is_last  = 1'b0;
        n_i      = i_o;
        n_j      = j_o;
        n_cx     = wid_center_o;
        n_cy     = hei_center_o;
        n_cw     = cnt_w_o;
        n_ch     = cnt_h_o;
        n_sx     = sub_x;
        n_sy     = sub_y;
        if (!mode_q) begin
            is_last = col_last && row_last;
            if (!col_last) begin
                n_cw = cnt_w_o + CNT_W'(1);
                n_cx = step_cx;
            end else begin
                n_cw = '0;
                n_cx = base_cx;
                n_ch = cnt_h_o + CNT_W'(1);
                n_cy = step_cy;
            end
            n_i = n_cx;
            n_j = n_cy;
        end else begin
            is_last = (i_o == x_max) && (j_o == y_max);
            if (i_o != x_max) begin
                n_i = i_o + COORD_W'(1);
                // The last column absorbs the remainder pixels, so its sub-counter keeps running.
                if (sub_x == cell_w - BW'(1) && !col_last) begin
                    n_sx = '0;
                    n_cw = cnt_w_o + CNT_W'(1);
                    n_cx = step_cx;
                end else begin
                    n_sx = sub_x + BW'(1);
                end
            end else begin
                n_i  = x_min;
                n_sx = '0;
                n_cw = '0;
                n_cx = base_cx;
                n_j  = j_o + COORD_W'(1);
                if (sub_y == cell_h - BW'(1) && !row_last) begin
                    n_sy = '0;
                    n_ch = cnt_h_o + CNT_W'(1);
                    n_cy = step_cy;
                end else begin
                    n_sy = sub_y + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_en) begin
        if (reset) begin
            state        <= IDLE;
            knn_en_q     <= 1'b0;
            mode_q       <= 1'b0;
            primed       <= 1'b0;
            lu_x_q       <= '0;
            lu_y_q       <= '0;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
            x_min        <= '0;
            y_min        <= '0;
            x_max        <= '0;
            y_max        <= '0;
            cell_w       <= '0;
            cell_h       <= '0;
            sub_x        <= '0;
            sub_y        <= '0;
            out_valid    <= 1'b0;
            i_o          <= '0;
            j_o          <= '0;
            cnt_w_o      <= '0;
            cnt_h_o      <= '0;
            wid_center_o <= '0;
            hei_center_o <= '0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            knn_fin_o    <= 1'b0;
        end else begin
            knn_en_q  <= knn_en;
            err_o     <= 1'b0;
            knn_fin_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (knn_en && !knn_en_q && dic_end) begin
                        lu_x_q <= postion_lu_x;
                        lu_y_q <= postion_lu_y;
                        rd_x_q <= postion_rd_x;
                        rd_y_q <= postion_rd_y;
                        mode_q <= mode_i;
                        busy_o <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    x_min  <= g_x_min;
                    x_max  <= g_x_max;
                    y_min  <= g_y_min;
                    y_max  <= g_y_max;
                    cell_w <= g_box_w >> GRID_W_LOG2;
                    cell_h <= g_box_h >> GRID_H_LOG2;
                    primed <= 1'b0;
                    state  <= SCAN;
                end
                SCAN: begin
                    // First SCAN cycle consumes the registered geometry: reject or load beat 0.
                    if (!primed) begin
                        primed <= 1'b1;
                        if (cell_w == '0 || cell_h == '0) begin
                            err_o     <= 1'b1;
                            knn_fin_o <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_valid    <= 1'b1;
                            i_o          <= mode_q ? x_min : base_cx;
                            j_o          <= mode_q ? y_min : base_cy;
                            cnt_w_o      <= '0;
                            cnt_h_o      <= '0;
                            wid_center_o <= base_cx;
                            hei_center_o <= base_cy;
                            sub_x        <= '0;
                            sub_y        <= '0;
                        end
                    end else if (out_ready) begin
                        if (is_last) begin
                            out_valid <= 1'b0;
                            knn_fin_o <= 1'b1;
                            state     <= DONE;
                        end else begin
                            i_o          <= n_i;
                            j_o          <= n_j;
                            cnt_w_o      <= n_cw;
                            cnt_h_o      <= n_ch;
                            wid_center_o <= n_cx;
                            hei_center_o <= n_cy;
                            sub_x        <= n_sx;
                            sub_y        <= n_sy;
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
`ifdef KNN_ABORT_EN
            if (knn_abort_i && (state == SETUP || state == SCAN)) begin
                out_valid <= 1'b0;
                err_o     <= 1'b0;
                knn_fin_o <= 1'b0;
                busy_o    <= 1'b0;
                state     <= IDLE;
            end
`endif
        end
    end
endmodule

// File: tb/tb_knn_grid_scan.sv
// Self-checking bench for knn_grid_scan: expected beat lists are generated per run from the box
// geometry and compared on every valid cycle; define KNN_ABORT_EN to also exercise the abort input.
module tb_knn_grid_scan;
    localparam int COORD_W = 10;
    localparam int CNT_W   = 4;
    localparam int GW      = 4;
    localparam int GH      = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               dic_end = 1'b1;
    logic               knn_en = 1'b0;
    logic               mode_i = 1'b0;
    logic [COORD_W-1:0] lu_x = '0, lu_y = '0, rd_x = '0, rd_y = '0;
    logic               out_ready = 1'b1;
    logic               out_valid;
    logic [COORD_W-1:0] i_o, j_o, wid_center_o, hei_center_o;
    logic [CNT_W-1:0]   cnt_w_o, cnt_h_o;
    logic               busy_o, err_o, knn_fin_o;
`ifdef KNN_ABORT_EN
    logic               knn_abort_i = 1'b0;
`endif

    always #5 clk = ~clk;

    knn_grid_scan #(.COORD_W(COORD_W), .GRID_W_LOG2(2), .GRID_H_LOG2(2), .CNT_W(CNT_W)) dut (
        .clk_en(clk), .reset(reset), .dic_end(dic_end), .knn_en(knn_en), .mode_i(mode_i),
        .postion_lu_x(lu_x), .postion_lu_y(lu_y), .postion_rd_x(rd_x), .postion_rd_y(rd_y),
        .out_ready(out_ready),
`ifdef KNN_ABORT_EN
        .knn_abort_i(knn_abort_i),
`endif
        .out_valid(out_valid), .i_o(i_o), .j_o(j_o), .cnt_w_o(cnt_w_o), .cnt_h_o(cnt_h_o),
        .wid_center_o(wid_center_o), .hei_center_o(hei_center_o),
        .busy_o(busy_o), .err_o(err_o), .knn_fin_o(knn_fin_o)
    );

    typedef struct {int i; int j; int c; int r; int wc; int hc;} beat_t;

    beat_t exp_q[$];
    beat_t got[$];
    int    checks = 0, errors = 0;
    bit    fin_pending = 0, fin_seen = 0, deg_run = 0, exp_deg = 0;
    int    exp_n = 0, ready_mode = 0, stall_left = 0, stall_hits = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input beat_t a, input beat_t e);
        checks++;
        if (a.i != e.i || a.j != e.j || a.c != e.c || a.r != e.r || a.wc != e.wc || a.hc != e.hc) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got i=%0d j=%0d c=%0d r=%0d wc=%0d hc=%0d expected i=%0d j=%0d c=%0d r=%0d wc=%0d hc=%0d",
                         name, a.i, a.j, a.c, a.r, a.wc, a.hc, e.i, e.j, e.c, e.r, e.wc, e.hc);
        end
    endtask

    // Reference: enumerate the stream directly from the grid geometry.
    task automatic build(input int lx, input int ly, input int rx, input int ry, input bit md);
        int xmin, xmax, ymin, ymax, cw, ch;
        xmin = (lx < rx) ? lx : rx;
        xmax = (lx < rx) ? rx : lx;
        ymin = (ly < ry) ? ly : ry;
        ymax = (ly < ry) ? ry : ly;
        cw = (xmax - xmin + 1) / GW;
        ch = (ymax - ymin + 1) / GH;
        exp_q.delete();
        exp_deg = (cw == 0) || (ch == 0);
        if (!exp_deg) begin
            if (!md) begin
                for (int r = 0; r < GH; r++)
                    for (int c = 0; c < GW; c++) begin
                        int cx, cy;
                        cx = xmin + c * cw + cw / 2;
                        cy = ymin + r * ch + ch / 2;
                        exp_q.push_back('{cx, cy, c, r, cx, cy});
                    end
            end else begin
                for (int y = ymin; y <= ymax; y++)
                    for (int x = xmin; x <= xmax; x++) begin
                        int c, r;
                        c = (x - xmin) / cw;
                        r = (y - ymin) / ch;
                        if (c > GW - 1) c = GW - 1;
                        if (r > GH - 1) r = GH - 1;
                        exp_q.push_back('{x, y, c, r, xmin + c * cw + cw / 2, ymin + r * ch + ch / 2});
                    end
            end
        end
        exp_n = exp_q.size();
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 1) out_ready = ($urandom_range(3) != 0);
        else if (ready_mode == 2 && got.size() == 4 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else out_ready = 1'b1;
    end

    always @(negedge clk) begin
        bit    exp_fin;
        beat_t a;
        if (!reset) begin
            exp_fin = fin_pending;
            fin_pending = 1'b0;
            if (knn_fin_o) fin_seen = 1'b1;
            if (!deg_run) begin
                if (exp_fin || knn_fin_o) begin
                    chk("fin_pulse", int'(knn_fin_o), int'(exp_fin));
                    chk("fin_valid_low", int'(out_valid), 0);
                end
                if (err_o) chk("unexpected_err", int'(err_o), 0);
            end
            if (out_valid) begin
                a = '{int'(i_o), int'(j_o), int'(cnt_w_o), int'(cnt_h_o), int'(wid_center_o), int'(hei_center_o)};
                chk("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk_beat("beat", a, exp_q[0]);
                    if (out_ready) begin
                        got.push_back(a);
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) fin_pending = 1'b1;
                    end
                end
                if (ready_mode == 2 && !out_ready) begin
                    stall_hits++;
                    chk_beat("stall_hold", a, '{125, 275, 0, 1, 125, 275});
                end
            end
        end
    end

    task automatic prep(input int lx, input int ly, input int rx, input int ry, input bit md, input int rmode);
        build(lx, ly, rx, ry, md);
        deg_run = exp_deg;
        fin_pending = 1'b0;
        fin_seen = 1'b0;
        got.delete();
        ready_mode = rmode;
        stall_left = 3;
        stall_hits = 0;
        knn_en = 1'b0;
        lu_x = COORD_W'(lx);
        lu_y = COORD_W'(ly);
        rd_x = COORD_W'(rx);
        rd_y = COORD_W'(ry);
        mode_i = md;
    endtask

    task automatic launch();
        @(posedge clk);
        #1 knn_en = 1'b1;
        @(posedge clk);
        #1 knn_en = 1'b0;
        lu_x = COORD_W'($urandom);
        lu_y = COORD_W'($urandom);
        rd_x = COORD_W'($urandom);
        rd_y = COORD_W'($urandom);
        mode_i = 1'($urandom);
        chk("busy_in_setup", int'(busy_o), 1);
        @(posedge clk);
        #1 chk("no_valid_before_latency", int'(out_valid), 0);
        @(posedge clk);
        #1;
        if (exp_deg) begin
            chk("deg_err", int'(err_o), 1);
            chk("deg_fin", int'(knn_fin_o), 1);
            chk("deg_valid", int'(out_valid), 0);
        end else chk("first_valid_latency", int'(out_valid), 1);
    endtask

    task automatic finish(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60000; k++) begin
            @(posedge clk);
            if (fin_seen) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_fin_seen"}, int'(done), 1);
        #1 chk({tag, "_idle_busy"}, int'(busy_o), 0);
        chk({tag, "_beats"}, got.size(), exp_n);
        chk({tag, "_leftover"}, exp_q.size(), 0);
    endtask

    task automatic run_box(input string tag, input int lx, input int ly, input int rx, input int ry,
                           input bit md, input int rmode);
        prep(lx, ly, rx, ry, md, rmode);
        launch();
        finish(tag);
    endtask

    task automatic chk_lit(input string name, input int idx, input int i, input int j, input int c, input int r);
        beat_t b;
        b = '{-1, -1, -1, -1, -1, -1};
        if (idx < got.size()) b = got[idx];
        checks++;
        if (b.i != i || b.j != j || b.c != c || b.r != r) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got i=%0d j=%0d c=%0d r=%0d expected i=%0d j=%0d c=%0d r=%0d",
                         name, b.i, b.j, b.c, b.r, i, j, c, r);
        end
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (got.size() >= n) break;
        end
        chk("reached_beat7", got.size(), n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("reset_state", int'({out_valid, i_o, j_o, cnt_w_o, cnt_h_o, wid_center_o, hei_center_o,
                                     busy_o, err_o, knn_fin_o} != '0), 0);
        reset = 1'b0;

        dic_end = 1'b0;
        @(posedge clk);
        #1 knn_en = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("dic_low_idle", int'(busy_o), 0);
        dic_end = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("held_en_no_start", int'(busy_o), 0);

        run_box("centre", 100, 400, 300, 200, 1'b0, 0);
        chk("centre_count", got.size(), 16);
        chk_lit("centre_first", 0, 125, 225, 0, 0);
        chk_lit("centre_fifth", 4, 125, 275, 0, 1);
        chk_lit("centre_last", 15, 275, 375, 3, 3);

        run_box("pixel", 100, 400, 300, 200, 1'b1, 0);
        chk("pixel_count", got.size(), 40401);
        chk_lit("pixel_x149", 49, 149, 200, 0, 0);
        chk_lit("pixel_x150", 50, 150, 200, 1, 0);
        chk_lit("pixel_x300", 200, 300, 200, 3, 0);
        chk_lit("pixel_last", 40400, 300, 400, 3, 3);

        run_box("stall", 100, 400, 300, 200, 1'b0, 2);
        chk("stall_cycles", stall_hits, 3);

        run_box("degenerate", 10, 10, 12, 50, 1'b0, 0);

        prep(100, 200, 140, 230, 1'b1, 0);
        launch();
        wait_beats(6);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 chk("reset_midrun_outputs", int'({out_valid, i_o, j_o, cnt_w_o, cnt_h_o, wid_center_o, hei_center_o,
                                              busy_o, err_o, knn_fin_o} != '0), 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1 chk("reset_no_fin", int'(fin_seen), 0);
        run_box("restart", 140, 230, 100, 200, 1'b1, 1);
        chk_lit("restart_first", 0, 100, 200, 0, 0);

`ifdef KNN_ABORT_EN
        prep(100, 200, 140, 230, 1'b1, 0);
        launch();
        wait_beats(6);
        #1 knn_abort_i = 1'b1;
        @(posedge clk);
        #1 knn_abort_i = 1'b0;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy_o), 0);
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1 chk("abort_no_fin", int'(fin_seen), 0);
`endif

        for (int t = 0; t < 16; t++) begin
            int x0, y0, x1, y1;
            bit md;
            md = 1'($urandom_range(1));
            if (!md) begin
                x0 = $urandom_range(1023);
                y0 = $urandom_range(1023);
                x1 = $urandom_range(1023);
                y1 = $urandom_range(1023);
            end else begin
                x0 = $urandom_range(1000);
                y0 = $urandom_range(1000);
                x1 = x0 + $urandom_range(23);
                y1 = y0 + $urandom_range(23);
                if ($urandom_range(1) == 1) begin
                    int tmp;
                    tmp = x0; x0 = x1; x1 = tmp;
                end
            end
            run_box("random", x0, y0, x1, y1, md, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
